ifu_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer in front of the word-addressed instruction ROM.

---
 rtl/ifu_pkg.sv | 26 ++
 rtl/ifu_fifo.sv | 66 ++++++
 rtl/ifu_fifo_chk.sv | 11 +
 rtl/ifu_fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ifu_entry_t;

  // Legal fetch: word aligned and inside the ROM window starting at base
  function automatic logic ifu_pc_legal(input logic [31:0] pc, input logic [31:0] base,
                                        input int unsigned aw);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'd4 << aw);
    return (pc[1:0] == 2'b00) && (pc >= base) && ({1'b0, pc} < limit);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of {pc, instr, exc} entries with flush; head entry is always presented.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  ifu_entry_t               push_data,
  input  logic                     pop,
  output ifu_entry_t               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  ifu_entry_t    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;
  logic          full_s;

  assign full_s    = (count_r == FULL_CNT);
  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && (!full_s || do_pop_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; flush drops all entries but leaves storage as is
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + {{PW{1'b0}}, do_push_s} - {{PW{1'b0}}, do_pop_s};
    end
  end

  ifu_fifo_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .full  (full_s)
  );

endmodule

// File: rtl/ifu_fifo_chk.sv
// Protocol checker for the prefetch FIFO: a landing response must always find room.
module ifu_fifo_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: fetch PC, 1-cycle ROM latency absorption, prefetch FIFO, redirect/halt.
// Define IFU_ADDR_CHECK_EN to turn illegal fetch addresses into exception entries instead of ROM reads.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter int          IM_AW     = 10,
  parameter int          BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_rd_en,
  output logic [IM_AW-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             out_exc,
  output logic             halted
);

  localparam int          CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = BUF_DEPTH[CW:0];

  ifu_state_e    state_r;
  ifu_state_e    state_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   pc_q_r;
  logic          inflight_r;
  logic          inflight_exc_r;
  logic          inflight_epoch_r;
  logic          epoch_r;
  logic [CW-1:0] count_s;
  logic [CW:0]   occ_s;
  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic          bad_issue_s;
  logic          pc_legal_s;
  ifu_entry_t    push_entry_s;
  ifu_entry_t    head_s;

`ifdef IFU_ADDR_CHECK_EN
  assign pc_legal_s = ifu_pc_legal(fetch_pc_r, RESET_PC, IM_AW);
`else
  assign pc_legal_s = 1'b1;
`endif

  // Occupancy after this cycle's pop and landing; lets a pop free a slot for back-to-back issue
  assign out_valid = (count_s != '0);
  assign pop_s     = out_valid && out_ready;
  assign occ_s     = {1'b0, count_s} - {{CW{1'b0}}, pop_s} + {{CW{1'b0}}, inflight_r};
  assign push_s    = inflight_r && (inflight_epoch_r == epoch_r);

  assign push_entry_s.pc    = pc_q_r;
  assign push_entry_s.instr = inflight_exc_r ? 32'h0000_0000 : imem_rdata;
  assign push_entry_s.exc   = inflight_exc_r;

  assign imem_rd_en = issue_s;
  assign imem_addr  = fetch_pc_r[IM_AW+1:2];
  assign out_pc     = head_s.pc;
  assign out_instr  = head_s.instr;
  assign out_exc    = head_s.exc;
  assign halted     = (state_r == HALT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_s;
    end
  end

  // Issue decision and next state; redirect overrides halt and any pending issue
  always_comb begin
    state_s     = state_r;
    issue_s     = 1'b0;
    bad_issue_s = 1'b0;
    if ((state_r == RUN) && !redirect_valid && (occ_s < DEPTH_W)) begin
      issue_s     = pc_legal_s;
      bad_issue_s = !pc_legal_s;
    end else begin
      issue_s     = 1'b0;
      bad_issue_s = 1'b0;
    end
    if (redirect_valid) begin
      state_s = RUN;
    end else begin
      case (state_r)
        BOOT: state_s = RUN;
        RUN: begin
          if (halt_req || bad_issue_s) begin
            state_s = HALT;
          end else begin
            state_s = RUN;
          end
        end
        HALT:    state_s = HALT;
        default: state_s = BOOT;
      endcase
    end
  end

  // Fetch PC, in-flight read tag and redirect epoch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r       <= RESET_PC;
      pc_q_r           <= 32'h0000_0000;
      inflight_r       <= 1'b0;
      inflight_exc_r   <= 1'b0;
      inflight_epoch_r <= 1'b0;
      epoch_r          <= 1'b0;
    end else begin
      inflight_r       <= issue_s || bad_issue_s;
      inflight_exc_r   <= bad_issue_s;
      inflight_epoch_r <= epoch_r;
      if (issue_s || bad_issue_s) begin
        pc_q_r <= fetch_pc_r;
      end
      if (redirect_valid) begin
        epoch_r    <= !epoch_r;
        fetch_pc_r <= redirect_pc;
      end else if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
    end
  end

  ifu_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed vector table, corner sequences, random vs. queue model.
module tb_ifu_fetch_ctrl;

`ifdef IFU_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam int DEPTH  = 2;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_rd_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;
  logic        halted;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_exc        (out_exc),
    .halted         (halted)
  );

  logic [31:0] rom [1024];
  initial for (int k = 0; k < 1024; k++) rom[k] = 32'h1000_0000 + 32'(k);
  always @(posedge clk) if (imem_rd_en) imem_rdata <= rom[imem_addr];

  // Reference model: fetch unit as a queue of delivered entries plus one pending read
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic exc; } ment_t;
  ment_t       mq[$];
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic        m_pend_exc;

  logic        s_valid, s_rd_en, s_halted, s_exc;
  logic [31:0] s_pc, s_instr;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + {22'd0, pc[11:2]};
  endfunction

  function automatic logic pc_ok(input logic [31:0] pc);
    return !CHECK_EN || ((pc[1:0] == 2'b00) && (pc >= 32'h3000) && (pc < 32'h4000));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_exc", 32'(out_exc), 32'd0);
    m_mode = M_BOOT; m_pc = 32'h3000; mq.delete(); m_pend = 1'b0;
  endtask

  // One clock: drive inputs, compare DUT with model, then advance the model across the edge
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc, input logic hlt);
    logic  m_valid, m_pop, m_try, m_legal;
    int    occ;
    ment_t e;
    @(negedge clk);
    reset = 1'b0; out_ready = rdy; redirect_valid = redir; redirect_pc = rpc; halt_req = hlt;
    #1;
    s_valid = out_valid; s_rd_en = imem_rd_en; s_halted = halted; s_exc = out_exc;
    s_pc = out_pc; s_instr = out_instr;
    m_valid = (mq.size() > 0);
    m_pop   = m_valid && rdy;
    occ     = mq.size() - (m_pop ? 1 : 0) + (m_pend ? 1 : 0);
    m_legal = pc_ok(m_pc);
    m_try   = (m_mode == M_RUN) && !redir && (occ < DEPTH);
    chk("m_valid", 32'(out_valid), 32'(m_valid));
    chk("m_halted", 32'(halted), 32'(m_mode == M_HALT));
    chk("m_rd_en", 32'(imem_rd_en), 32'(m_try && m_legal));
    if (m_try && m_legal) chk("m_addr", 32'(imem_addr), 32'(m_pc[11:2]));
    if (m_valid) begin
      chk("m_pc", out_pc, mq[0].pc);
      chk("m_instr", out_instr, mq[0].instr);
      chk("m_exc", 32'(out_exc), 32'(mq[0].exc));
    end
    if (redir) begin
      mq.delete(); m_pend = 1'b0; m_pc = rpc; m_mode = M_RUN;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_pend) begin
        e.pc = m_pend_pc; e.exc = m_pend_exc;
        e.instr = m_pend_exc ? 32'h0 : rom_word(m_pend_pc);
        mq.push_back(e);
      end
      m_pend = m_try; m_pend_pc = m_pc; m_pend_exc = !m_legal;
      if (m_mode == M_BOOT) m_mode = M_RUN;
      else if (m_mode == M_RUN && (hlt || (m_try && !m_legal))) m_mode = M_HALT;
      if (m_try && m_legal) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic run_until_valid(input string tag, output logic any_rd);
    logic seen;
    seen = 1'b0; any_rd = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      seen = s_valid;
      if (!seen) any_rd = any_rd | s_rd_en;
    end
    chk({tag, "_got_valid"}, 32'(seen), 32'd1);
  endtask

  typedef struct { logic rst; logic rdy; logic v; logic [31:0] pc; logic [31:0] instr; logic rd; } vec_t;
  vec_t vecs [21];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic v,
                              input logic [31:0] pc, input logic [31:0] instr, input logic rd);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.v = v; r.pc = pc; r.instr = instr; r.rd = rd;
    return r;
  endfunction

  initial begin
    logic        any_rd;
    logic        rdy, redir, hlt;
    logic [31:0] rpc;

    // reset / streaming with ready=1 / back-pressure to full / reset with full FIFO / restart
    vecs[0]  = mk(1, 1, 0, 32'h0,    32'h0,         0);
    vecs[1]  = mk(0, 1, 0, 32'h0,    32'h0,         0);
    vecs[2]  = mk(0, 1, 0, 32'h0,    32'h0,         1);
    vecs[3]  = mk(0, 1, 0, 32'h0,    32'h0,         1);
    vecs[4]  = mk(0, 1, 1, 32'h3000, 32'h1000_0000, 1);
    vecs[5]  = mk(0, 1, 1, 32'h3004, 32'h1000_0001, 1);
    vecs[6]  = mk(0, 1, 1, 32'h3008, 32'h1000_0002, 1);
    vecs[7]  = mk(1, 0, 0, 32'h0,    32'h0,         0);
    vecs[8]  = mk(0, 0, 0, 32'h0,    32'h0,         0);
    vecs[9]  = mk(0, 0, 0, 32'h0,    32'h0,         1);
    vecs[10] = mk(0, 0, 0, 32'h0,    32'h0,         1);
    vecs[11] = mk(0, 0, 1, 32'h3000, 32'h1000_0000, 0);
    vecs[12] = mk(0, 0, 1, 32'h3000, 32'h1000_0000, 0);
    vecs[13] = mk(0, 0, 1, 32'h3000, 32'h1000_0000, 0);
    vecs[14] = mk(0, 0, 1, 32'h3000, 32'h1000_0000, 0);
    vecs[15] = mk(1, 1, 0, 32'h0,    32'h0,         0);
    vecs[16] = mk(0, 1, 0, 32'h0,    32'h0,         0);
    vecs[17] = mk(0, 1, 0, 32'h0,    32'h0,         1);
    vecs[18] = mk(0, 1, 0, 32'h0,    32'h0,         1);
    vecs[19] = mk(0, 1, 1, 32'h3000, 32'h1000_0000, 1);
    vecs[20] = mk(0, 1, 1, 32'h3004, 32'h1000_0001, 1);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; out_ready = vecs[i].rdy;
      redirect_valid = 1'b0; halt_req = 1'b0; redirect_pc = 32'h0;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d_rd_en", i), 32'(imem_rd_en), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'd0);
      if (vecs[i].v || vecs[i].rst) begin
        chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].pc);
        chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].instr);
        chk($sformatf("vec%0d_exc", i), 32'(out_exc), 32'd0);
      end
    end

    // redirect while a read is in flight
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t3_inflight", 32'(s_rd_en), 32'd1);
    tick(1'b1, 1'b1, 32'h3040, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t3_flushed", 32'(s_valid), 32'd0);
    run_until_valid("t3", any_rd);
    chk("t3_pc", s_pc, 32'h3040);
    chk("t3_instr", s_instr, 32'h1000_0010);

    // halt at 0x3008, drain, then resume by redirect
    tick(1'b1, 1'b1, 32'h3000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (mq.size() > 0 && mq[0].pc == 32'h3008) break;
      tick(1'b1, 1'b0, 32'h0, 1'b0);
    end
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t4_pc_at_halt", s_pc, 32'h3008);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("t4_no_issue", 32'(s_rd_en), 32'd0);
    end
    chk("t4_halted", 32'(s_halted), 32'd1);
    chk("t4_drained", 32'(s_valid), 32'd0);
    tick(1'b1, 1'b1, 32'h3000, 1'b0);
    run_until_valid("t4", any_rd);
    chk("t4_resume_pc", s_pc, 32'h3000);
    chk("t4_resume_halted", 32'(s_halted), 32'd0);

`ifdef IFU_ADDR_CHECK_EN
    // misaligned redirect becomes an exception entry with no ROM read
    tick(1'b1, 1'b1, 32'h3002, 1'b0);
    run_until_valid("t6", any_rd);
    chk("t6_exc", 32'(s_exc), 32'd1);
    chk("t6_pc", s_pc, 32'h3002);
    chk("t6_instr", s_instr, 32'h0);
    chk("t6_halted", 32'(s_halted), 32'd1);
    chk("t6_no_read", 32'(any_rd), 32'd0);
    tick(1'b1, 1'b1, 32'h3000, 1'b0);
`endif

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 11) == 0);
      hlt   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'h3000 + 32'($urandom_range(0, 4200));
      else rpc = 32'h3000 + 32'(4 * $urandom_range(0, 1023));
      tick(rdy, redir, rpc, hlt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule
